// File: rtl/tl_ul_sram_responder_if.sv
// ---------------------------------------------------------------------------
// tl_ul_sram_responder_if
//   TileLink-UL A/D channel pair between a core-side requester (master) and
//   the SRAM responder (slave).
//
//   Handshake: a beat transfers on the rising clock edge where valid and ready
//   are both high. The sender holds valid and every payload field stable from
//   the cycle valid rises until that transfer edge. The receiver may raise or
//   drop ready at any time. valid never waits for ready.
//
//   Parameters: SOURCE_W  width of a_source / d_source
//   Modports  : master  drives A payload + d_ready, observes a_ready + D
//               slave   drives a_ready + D payload, observes A + d_ready
// ---------------------------------------------------------------------------
interface tl_ul_sram_responder_if #(
    parameter int unsigned SOURCE_W = 3
);
    // A channel (request)
    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [2:0]          a_param;
    logic [1:0]          a_size;
    logic [SOURCE_W-1:0] a_source;
    logic [31:0]         a_address;
    logic [3:0]          a_mask;
    logic [31:0]         a_data;
    logic                a_corrupt;

    // D channel (response)
    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [1:0]          d_param;
    logic [1:0]          d_size;
    logic [SOURCE_W-1:0] d_source;
    logic                d_sink;
    logic                d_denied;
    logic [31:0]         d_data;
    logic                d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, a_corrupt, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_denied, d_data, d_corrupt
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, a_corrupt, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_denied, d_data, d_corrupt
    );
endinterface

// File: rtl/tl_ul_sram_responder.sv
// ---------------------------------------------------------------------------
// tl_ul_sram_responder
//   TileLink-UL manager that terminates an A/D channel pair into a local
//   word-wide SRAM. Get returns AccessAckData, PutFull/PutPartial write the
//   masked byte lanes and return AccessAck, Hint returns HintAck, Arith and
//   Logical (and opcodes 6/7) are refused. One request is outstanding; the
//   single D-holding register still sustains one beat per cycle because a new
//   request is accepted in the same cycle the held response drains.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   BASE_ADDR    byte base of the decoded window (aligned to DEPTH_WORDS*4)
//   SOURCE_W     request ID width
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset
//   parity_inject  (TL_RESP_PARITY_EN only) flips stored parity of lanes
//                  written while high
//   tl             slave side of the TL-UL A/D channel pair
//   debug_state    D-holding register state: 0 EMPTY, 1 FULL
//
// Configuration
//   TL_RESP_PARITY_EN  when defined, one even-parity bit is stored per byte
//                      and a Get on a word with any bad-parity byte returns
//                      d_corrupt=1 with the data still delivered.
// ---------------------------------------------------------------------------
module tl_ul_sram_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned SOURCE_W    = 3
) (
    input  logic                         clock,
    input  logic                         reset,
`ifdef TL_RESP_PARITY_EN
    input  logic                         parity_inject,
`endif
    tl_ul_sram_responder_if.slave        tl,
    output logic                         debug_state
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    // A-channel opcodes
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_HINT        = 3'd5;

    // D-channel opcodes
    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] OP_HINT_ACK        = 3'd2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state;

    // Registered D payload
    logic [2:0]            d_opcode_q;
    logic [1:0]            d_size_q;
    logic [SOURCE_W-1:0]   d_source_q;
    logic                  d_denied_q;
    logic [31:0]           d_data_q;
    logic                  d_corrupt_q;

    // Handshake
    logic                  a_fire;
    logic                  d_fire;

    // Request decode
    logic [31:0]           offset;
    logic [IDX_W-1:0]      idx;
    logic                  in_window;
    logic                  misaligned;
    logic                  is_get;
    logic                  is_put;
    logic                  is_hint;
    logic                  req_denied;
    logic                  write_en;

    // Storage
    logic [31:0]           mem [DEPTH_WORDS];
    logic [31:0]           rd_word;
    logic                  parity_bad;

    // Next D payload
    logic [2:0]            next_opcode;
    logic                  next_denied;
    logic [31:0]           next_data;
    logic                  next_corrupt;

    // -----------------------------------------------------------------------
    // Handshake: the slot may take a new request whenever it is empty or its
    // current occupant leaves on this same edge.
    // -----------------------------------------------------------------------
    assign tl.d_valid = (state == FULL);
    assign tl.a_ready = (state == EMPTY) | tl.d_ready;
    assign a_fire     = tl.a_valid & tl.a_ready;
    assign d_fire     = tl.d_valid & tl.d_ready;

    // -----------------------------------------------------------------------
    // Address decode. The subtraction wraps for addresses below the base, so
    // any nonzero bit above the window size means "outside".
    // -----------------------------------------------------------------------
    assign offset    = tl.a_address - BASE_ADDR;
    assign in_window = (offset[31:IDX_W+2] == '0);
    assign idx       = offset[IDX_W+1:2];

    always_comb begin
        misaligned = 1'b0;
        case (tl.a_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = tl.a_address[0];
            2'd2:    misaligned = |tl.a_address[1:0];
            default: misaligned = 1'b1;   // 8-byte access does not fit a 32-bit beat
        endcase
    end

    assign is_get  = (tl.a_opcode == OP_GET);
    assign is_put  = (tl.a_opcode == OP_PUT_FULL) | (tl.a_opcode == OP_PUT_PARTIAL);
    assign is_hint = (tl.a_opcode == OP_HINT);

    // Poisoned write data is refused rather than stored.
    assign req_denied = ~in_window | misaligned | (is_put & tl.a_corrupt);
    assign write_en   = a_fire & is_put & ~req_denied;

    // -----------------------------------------------------------------------
    // SRAM array. Not reset: contents survive reset by design.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (tl.a_mask[i]) begin
                    mem[idx][8*i +: 8] <= tl.a_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem[idx];

`ifdef TL_RESP_PARITY_EN
    // One even-parity bit per byte lane, written together with its byte.
    logic [3:0] par_mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (tl.a_mask[i]) begin
                    par_mem[idx][i] <= (^tl.a_data[8*i +: 8]) ^ parity_inject;
                end
            end
        end
    end

    always_comb begin
        parity_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((^rd_word[8*i +: 8]) != par_mem[idx][i]) begin
                parity_bad = 1'b1;
            end
        end
    end
`else
    assign parity_bad = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Response selection for the request currently on A.
    // -----------------------------------------------------------------------
    always_comb begin
        next_opcode  = OP_ACCESS_ACK;
        next_denied  = 1'b0;
        next_data    = 32'h0;
        next_corrupt = 1'b0;
        if (is_get) begin
            next_opcode = OP_ACCESS_ACK_DATA;
            if (req_denied) begin
                next_denied  = 1'b1;
                next_corrupt = 1'b1;
            end else begin
                next_data    = rd_word;
                next_corrupt = parity_bad;
            end
        end else if (is_put) begin
            next_opcode = OP_ACCESS_ACK;
            next_denied = req_denied;
        end else if (is_hint) begin
            // Hints are advisory: always acknowledged, never refused.
            next_opcode = OP_HINT_ACK;
        end else begin
            // Arith, Logical and the reserved opcodes 6/7 are not supported.
            next_opcode  = OP_ACCESS_ACK_DATA;
            next_denied  = 1'b1;
            next_corrupt = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // D-holding register. A new response loads on A fire (which also covers
    // the simultaneous D fire + A fire case); otherwise the payload is held
    // until d_ready, and the slot empties on a bare D fire.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            d_opcode_q  <= 3'd0;
            d_size_q    <= 2'd0;
            d_source_q  <= '0;
            d_denied_q  <= 1'b0;
            d_data_q    <= 32'h0;
            d_corrupt_q <= 1'b0;
        end else begin
            if (a_fire) begin
                state       <= FULL;
                d_opcode_q  <= next_opcode;
                d_size_q    <= tl.a_size;
                d_source_q  <= tl.a_source;
                d_denied_q  <= next_denied;
                d_data_q    <= next_data;
                d_corrupt_q <= next_corrupt;
            end else if (d_fire) begin
                state <= EMPTY;
            end
        end
    end

    assign tl.d_opcode  = d_opcode_q;
    assign tl.d_param   = 2'd0;
    assign tl.d_size    = d_size_q;
    assign tl.d_source  = d_source_q;
    assign tl.d_sink    = 1'b0;
    assign tl.d_denied  = d_denied_q;
    assign tl.d_data    = d_data_q;
    assign tl.d_corrupt = d_corrupt_q;

    assign debug_state = state;

    // a_param carries no meaning for this responder; the low offset bits are
    // covered by the alignment check on a_address instead.
    logic unused_inputs;
    assign unused_inputs = ^{tl.a_param, offset[1:0]};

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
module tb_tl_ul_sram_responder;

    localparam int          DEPTH  = 256;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          RESP_W = 42;  // opcode3 size2 source3 denied1 corrupt1 data32

    logic clock;
    logic reset;
    logic debug_state;
`ifdef TL_RESP_PARITY_EN
    logic parity_inject;
`endif

    tl_ul_sram_responder_if #(.SOURCE_W(3)) tl ();

    tl_ul_sram_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .SOURCE_W   (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
`ifdef TL_RESP_PARITY_EN
        .parity_inject(parity_inject),
`endif
        .tl           (tl),
        .debug_state  (debug_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [RESP_W-1:0] exp_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [3:0]  model_bad [DEPTH];

    logic [2:0]  last_op;
    logic [2:0]  last_src;
    logic        last_den;
    logic        last_cor;
    logic [31:0] last_data;

    bit   ready_mode = 1'b0;   // 1: random d_ready
    logic ready_val  = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: applies the access rules to the request on A.
    task automatic model_accept();
        logic [2:0]  op;
        logic [1:0]  sz;
        logic [31:0] addr;
        longint      off;
        bit          in_win;
        bit          denied;
        int          idx;
        logic [2:0]  r_op;
        logic        r_den;
        logic        r_cor;
        logic [31:0] r_data;
        op     = tl.a_opcode;
        sz     = tl.a_size;
        addr   = tl.a_address;
        off    = longint'(addr) - longint'(BASE);
        in_win = (off >= 0) && (off < DEPTH * 4);
        idx    = in_win ? int'(off / 4) : 0;
        denied = !in_win || (sz == 2'd3) || ((addr % (32'd1 << sz)) != 0);
        r_op = 3'd0; r_den = 1'b0; r_cor = 1'b0; r_data = 32'h0;
        case (op)
            3'd0, 3'd1: begin
                denied = denied || tl.a_corrupt;
                r_op   = 3'd0;
                r_den  = denied;
                if (!denied) begin
                    for (int i = 0; i < 4; i++) begin
                        if (tl.a_mask[i]) begin
                            model_mem[idx][8*i +: 8] = tl.a_data[8*i +: 8];
`ifdef TL_RESP_PARITY_EN
                            model_bad[idx][i] = parity_inject;
`else
                            model_bad[idx][i] = 1'b0;
`endif
                        end
                    end
                end
            end
            3'd4: begin
                r_op = 3'd1;
                if (denied) begin
                    r_den = 1'b1;
                    r_cor = 1'b1;
                end else begin
                    r_data = model_mem[idx];
                    r_cor  = |model_bad[idx];
                end
            end
            3'd5: r_op = 3'd2;
            default: begin
                r_op  = 3'd1;
                r_den = 1'b1;
                r_cor = 1'b1;
            end
        endcase
        exp_q.push_back({r_op, sz, tl.a_source, r_den, r_cor, r_data});
    endtask

    // Monitor: sampled at negedge; a handshake seen here fires on the next posedge.
    always @(negedge clock) begin
        if (!reset) begin
            if (tl.d_valid && tl.d_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_d", 64'(exp_q.size()), 64'd1);
                end else begin
                    logic [RESP_W-1:0] e;
                    e = exp_q.pop_front();
                    check("d_opcode",  64'(tl.d_opcode),  64'(e[41:39]));
                    check("d_size",    64'(tl.d_size),    64'(e[38:37]));
                    check("d_source",  64'(tl.d_source),  64'(e[36:34]));
                    check("d_denied",  64'(tl.d_denied),  64'(e[33]));
                    check("d_corrupt", 64'(tl.d_corrupt), 64'(e[32]));
                    check("d_data",    64'(tl.d_data),    64'(e[31:0]));
                    check("d_param",   64'(tl.d_param),   64'd0);
                    check("d_sink",    64'(tl.d_sink),    64'd0);
                    last_op   = tl.d_opcode;
                    last_src  = tl.d_source;
                    last_den  = tl.d_denied;
                    last_cor  = tl.d_corrupt;
                    last_data = tl.d_data;
                end
            end
            if (tl.a_valid && tl.a_ready) model_accept();
        end
    end

    // d_ready driver
    initial begin
        tl.d_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            tl.d_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_val;
        end
    end

    // ---------------- driver tasks ----------------
    // Entered and left at posedge+1.
    task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [2:0] src,
                        input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic cor);
        int n;
        tl.a_valid   = 1'b1;
        tl.a_opcode  = op;
        tl.a_param   = 3'($urandom_range(0, 7));
        tl.a_size    = size;
        tl.a_source  = src;
        tl.a_address = addr;
        tl.a_mask    = mask;
        tl.a_data    = data;
        tl.a_corrupt = cor;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!tl.a_ready && n < 100);
        if (!tl.a_ready) check("a_ready_timeout", 64'(tl.a_ready), 64'd1);
        @(posedge clock);
        #1;
        tl.a_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while (exp_q.size() != 0 && n < 500);
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int start;
        logic [RESP_W-1:0] front;
        tl.a_valid = 1'b0; tl.a_opcode = 3'd0; tl.a_param = 3'd0; tl.a_size = 2'd0;
        tl.a_source = 3'd0; tl.a_address = 32'h0; tl.a_mask = 4'h0; tl.a_data = 32'h0;
        tl.a_corrupt = 1'b0;
`ifdef TL_RESP_PARITY_EN
        parity_inject = 1'b0;
`endif
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_d_valid",  64'(tl.d_valid),  64'd0);
        check("rst_d_opcode", 64'(tl.d_opcode), 64'd0);
        check("rst_d_size",   64'(tl.d_size),   64'd0);
        check("rst_d_source", 64'(tl.d_source), 64'd0);
        check("rst_d_denied", 64'(tl.d_denied), 64'd0);
        check("rst_d_data",   64'(tl.d_data),   64'd0);
        check("rst_d_corrupt",64'(tl.d_corrupt),64'd0);
        check("rst_a_ready",  64'(tl.a_ready),  64'd1);
        check("rst_state",    64'(debug_state), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Preload every word so later Gets have defined contents.
        for (int i = 0; i < DEPTH; i++)
            send(3'd0, 2'd2, 3'($urandom_range(0, 7)), BASE + 32'(i * 4), 4'hF, $urandom(), 1'b0);
        drain();

        // PutFull then Get
        send(3'd0, 2'd2, 3'd2, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0);
        drain();
        check("putfull_opcode", 64'(last_op),  64'd0);
        check("putfull_source", 64'(last_src), 64'd2);
        check("putfull_denied", 64'(last_den), 64'd0);
        send(3'd4, 2'd2, 3'd1, 32'h8000_0010, 4'hF, 32'h0, 1'b0);
        drain();
        check("get_deadbeef", 64'(last_data), 64'hDEAD_BEEF);

        // PutPartial over it
        send(3'd1, 2'd2, 3'd3, 32'h8000_0010, 4'b0101, 32'h1122_3344, 1'b0);
        send(3'd4, 2'd2, 3'd4, 32'h8000_0010, 4'hF, 32'h0, 1'b0);
        drain();
        check("get_partial", 64'(last_data), 64'hDE22_BE44);

        // Backpressure: pending ack held for 5 cycles
        ready_val = 1'b0;
        @(posedge clock); #1;
        send(3'd0, 2'd2, 3'd6, 32'h8000_0020, 4'hF, 32'hCAFE_F00D, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            front = exp_q[0];
            check("bp_a_ready",   64'(tl.a_ready),  64'd0);
            check("bp_d_valid",   64'(tl.d_valid),  64'd1);
            check("bp_d_opcode",  64'(tl.d_opcode), 64'(front[41:39]));
            check("bp_d_source",  64'(tl.d_source), 64'(front[36:34]));
            check("bp_d_data",    64'(tl.d_data),   64'(front[31:0]));
        end
        ready_val = 1'b1;
        @(posedge clock); #1;
        // Back-to-back Gets: one acceptance per cycle
        send(3'd4, 2'd2, 3'd0, BASE, 4'hF, 32'h0, 1'b0);
        start = cyc;
        for (int k = 1; k < 8; k++)
            send(3'd4, 2'd2, 3'(k), BASE + 32'(k * 4), 4'hF, 32'h0, 1'b0);
        check("b2b_cycles", 64'(cyc - start), 64'd7);
        drain();

        // Denials
        send(3'd4, 2'd2, 3'd1, 32'h9000_0000, 4'hF, 32'h0, 1'b0);
        drain();
        check("oow_opcode",  64'(last_op),   64'd1);
        check("oow_denied",  64'(last_den),  64'd1);
        check("oow_corrupt", 64'(last_cor),  64'd1);
        check("oow_data",    64'(last_data), 64'd0);
        send(3'd4, 2'd2, 3'd1, 32'h8000_0002, 4'hF, 32'h0, 1'b0);
        drain();
        check("misalign_denied", 64'(last_den), 64'd1);
        send(3'd2, 2'd2, 3'd1, 32'h8000_0010, 4'hF, 32'h0BAD_0BAD, 1'b0);
        drain();
        check("arith_denied", 64'(last_den), 64'd1);
        send(3'd4, 2'd2, 3'd1, 32'h8000_0010, 4'hF, 32'h0, 1'b0);
        drain();
        check("arith_no_write", 64'(last_data), 64'hDE22_BE44);

        // Hint
        send(3'd5, 2'd2, 3'd5, 32'h8000_0040, 4'hF, 32'h0, 1'b0);
        drain();
        check("hint_opcode", 64'(last_op),  64'd2);
        check("hint_source", 64'(last_src), 64'd5);

        // Reset pulse while a response is pending
        ready_val = 1'b0;
        @(posedge clock); #1;
        send(3'd5, 2'd0, 3'd7, 32'h8000_0000, 4'h0, 32'h0, 1'b0);
        @(negedge clock);
        check("pre_rst_d_valid", 64'(tl.d_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("async_rst_d_valid", 64'(tl.d_valid), 64'd0);
        check("async_rst_state",   64'(debug_state), 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        check("post_rst_a_ready", 64'(tl.a_ready), 64'd1);
        ready_val = 1'b1;
        @(posedge clock); #1;

`ifdef TL_RESP_PARITY_EN
        parity_inject = 1'b1;
        send(3'd0, 2'd2, 3'd1, 32'h8000_0030, 4'hF, 32'h5A5A_1234, 1'b0);
        parity_inject = 1'b0;
        send(3'd4, 2'd2, 3'd2, 32'h8000_0030, 4'hF, 32'h0, 1'b0);
        drain();
        check("par_corrupt", 64'(last_cor),  64'd1);
        check("par_denied",  64'(last_den),  64'd0);
        check("par_data",    64'(last_data), 64'h5A5A_1234);
`endif

        // Randomized traffic against the model
        ready_mode = 1'b1;
        for (int t = 0; t < 400; t++) begin
            logic [2:0]  op;
            logic [1:0]  sz;
            logic [31:0] addr;
            int          r;
            int          w;
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) op = ($urandom_range(0, 1) != 0) ? 3'd4 : 3'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            w  = $urandom_range(0, DEPTH - 1);
            r  = $urandom_range(0, 11);
            case (r)
                0:       addr = $urandom();
                1:       addr = BASE + 32'(w * 4) + 32'($urandom_range(1, 3));
                2:       addr = BASE - 32'd4;
                3:       addr = BASE + 32'(DEPTH * 4);
                4:       addr = BASE + 32'((DEPTH - 1) * 4);
                default: addr = BASE + 32'(w * 4) + ((32'($urandom_range(0, 3)) >> sz) << sz);
            endcase
`ifdef TL_RESP_PARITY_EN
            parity_inject = ($urandom_range(0, 7) == 0);
`endif
            send(op, sz, 3'($urandom_range(0, 7)), addr, 4'($urandom_range(0, 15)),
                 $urandom(), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clock); #1;
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
